// File: rtl/jtframe_dual_ram_clr_pkg.sv
// Shared types for the clearable dual-port RAM: clear FSM encoding and byte lane width.
package jtframe_dual_ram_clr_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/jtframe_dual_ram_be_core.sv
// Bare two-port byte-enable memory array with registered read data and no reset.
// Each port has its own read and write address so the clear engine never steals a read.
module jtframe_dual_ram_be_core
  import jtframe_dual_ram_clr_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 10
) (
  input  logic             clk,
  input  logic [AW-1:0]    raddr0,
  input  logic [AW-1:0]    waddr0,
  input  logic [DW-1:0]    data0,
  input  logic [DW/8-1:0]  we0,
  output logic [DW-1:0]    q0,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    waddr1,
  input  logic [DW-1:0]    data1,
  input  logic [DW/8-1:0]  we1,
  output logic [DW-1:0]    q1
);

  localparam int unsigned BW    = DW / BYTE_W;
  localparam int unsigned DEPTH = 2 ** AW;

  (* ramstyle = "no_rw_check" *) logic [DW-1:0] mem [DEPTH];

  // Reads see the pre-write word; port 1 lanes land last on a shared address.
  always_ff @(posedge clk) begin
    q0 <= mem[raddr0];
    q1 <= mem[raddr1];
    for (int b = 0; b < BW; b++) begin
      if (we0[b]) mem[waddr0][b*BYTE_W +: BYTE_W] <= data0[b*BYTE_W +: BYTE_W];
      if (we1[b]) mem[waddr1][b*BYTE_W +: BYTE_W] <= data1[b*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/jtframe_dual_ram_clr.sv
// True dual-port byte-enable RAM with read-during-write selection, 1/2-cycle read latency
// and a clear engine that fills the whole array with CLRVAL at boot or on request.
module jtframe_dual_ram_clr
  import jtframe_dual_ram_clr_pkg::*;
#(
  parameter int unsigned   DW      = 16,
  parameter int unsigned   AW      = 10,
  parameter int unsigned   LAT     = 1,
  parameter int unsigned   RDW     = 0,
  parameter int unsigned   CLR_RST = 1,
  parameter logic [DW-1:0] CLRVAL  = '0,
  parameter                SYNFILE = ""
) (
  input  logic            rst_n,
  input  logic            clk,
  input  logic [AW-1:0]   addr0,
  input  logic [DW-1:0]   data0,
  input  logic [DW/8-1:0] we0,
  output logic [DW-1:0]   q0,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   data1,
  input  logic [DW/8-1:0] we1,
  output logic [DW-1:0]   q1,
  input  logic            clr,
  output logic            busy,
  output logic            done
);

  localparam int unsigned BW        = DW / BYTE_W;
  localparam clr_state_t  RST_STATE = (CLR_RST != 0) ? CLEAR : IDLE;
  localparam logic        BYPASS    = (RDW != 0);

  clr_state_t    state;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_nxt;
  logic [BW-1:0] wm0;
  logic [BW-1:0] wm1;
  logic [AW-1:0] wa1;
  logic [DW-1:0] wd1;
  logic [AW-1:0] raddr  [2];
  logic [DW-1:0] core_q [2];
  logic [BW-1:0] sel0   [2];
  logic [BW-1:0] sel1   [2];
  logic [BW-1:0] sel0_r [2];
  logic [BW-1:0] sel1_r [2];
  logic [DW-1:0] wd0_r;
  logic [DW-1:0] wd1_r;
  logic [DW-1:0] qv     [2];
  logic          vld;

  assign raddr[0] = addr0;
  assign raddr[1] = addr1;
  assign cnt_nxt  = cnt + (AW+1)'(1);

  // Clear FSM; the extra counter bit flags the step past the last address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      busy  <= (CLR_RST != 0);
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          if (clr) begin
            cnt <= '0;
          end else if (cnt_nxt[AW]) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Write steering: clear engine owns port 1, port 1 wins shared lanes otherwise.
  always_comb begin
    wm0 = '0;
    wm1 = we1;
    wa1 = addr1;
    wd1 = data1;
    if (busy) begin
      wm1 = '1;
      wa1 = cnt[AW-1:0];
      wd1 = CLRVAL;
    end else begin
      wm0 = (addr0 == addr1) ? (we0 & ~we1) : we0;
    end
    for (int p = 0; p < 2; p++) begin
      sel0[p] = {BW{BYPASS && (addr0 == raddr[p])}} & wm0;
      sel1[p] = {BW{BYPASS && (wa1 == raddr[p])}} & wm1;
    end
  end

  jtframe_dual_ram_be_core #(
    .DW (DW),
    .AW (AW)
  ) u_core (
    .clk    (clk),
    .raddr0 (addr0),
    .waddr0 (addr0),
    .data0  (data0),
    .we0    (wm0),
    .q0     (core_q[0]),
    .raddr1 (addr1),
    .waddr1 (wa1),
    .data1  (wd1),
    .we1    (wm1),
    .q1     (core_q[1])
  );

  // Bypass lane selects and write data, aligned with the core read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= 1'b0;
      wd0_r <= '0;
      wd1_r <= '0;
      for (int p = 0; p < 2; p++) begin
        sel0_r[p] <= '0;
        sel1_r[p] <= '0;
      end
    end else begin
      vld   <= 1'b1;
      wd0_r <= data0;
      wd1_r <= wd1;
      for (int p = 0; p < 2; p++) begin
        sel0_r[p] <= sel0[p];
        sel1_r[p] <= sel1[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      qv[p] = '0;
      for (int b = 0; b < BW; b++) begin
        if (sel1_r[p][b])      qv[p][b*BYTE_W +: BYTE_W] = wd1_r[b*BYTE_W +: BYTE_W];
        else if (sel0_r[p][b]) qv[p][b*BYTE_W +: BYTE_W] = wd0_r[b*BYTE_W +: BYTE_W];
        else                   qv[p][b*BYTE_W +: BYTE_W] = core_q[p][b*BYTE_W +: BYTE_W];
      end
      if (!vld) qv[p] = '0;
    end
  end

  if (LAT == 1) begin : g_lat1
    assign q0 = qv[0];
    assign q1 = qv[1];
  end else if (LAT == 2) begin : g_lat2
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q0 <= '0;
        q1 <= '0;
      end else begin
        q0 <= qv[0];
        q1 <= qv[1];
      end
    end
  end else begin : g_lat_bad
    $error("jtframe_dual_ram_clr: LAT must be 1 or 2");
  end

  if (SYNFILE != "") begin : g_synfile
    $warning("jtframe_dual_ram_clr: SYNFILE preload is not handled by this core");
  end

endmodule

// File: tb/tb_jtframe_dual_ram_clr.sv
// Scoreboard bench: LAT=1/RDW=0 and LAT=2/RDW=1 instances share stimulus, checked against a word model.
module tb_jtframe_dual_ram_clr;

  localparam int unsigned N  = 16;
  localparam logic [15:0] CV = 16'hA5A5;

  typedef struct {
    bit          c0;
    logic [15:0] e0;
    bit          c1;
    logic [15:0] e1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  addr0, addr1;
  logic [15:0] data0, data1;
  logic [1:0]  we0, we1;
  logic        clr;
  logic [15:0] qa0, qa1, qb0, qb1;
  logic        busya, donea, busyb, doneb;

  logic [15:0] model [N];
  bit          known [N];
  bit          mbusy;
  int          mcnt;
  bit          edone;
  exp_t        sa[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  jtframe_dual_ram_clr #(
    .DW(16), .AW(4), .LAT(1), .RDW(0), .CLR_RST(1), .CLRVAL(CV), .SYNFILE("")
  ) dut_a (
    .rst_n(rst_n), .clk(clk),
    .addr0(addr0), .data0(data0), .we0(we0), .q0(qa0),
    .addr1(addr1), .data1(data1), .we1(we1), .q1(qa1),
    .clr(clr), .busy(busya), .done(donea)
  );

  jtframe_dual_ram_clr #(
    .DW(16), .AW(4), .LAT(2), .RDW(1), .CLR_RST(1), .CLRVAL(CV), .SYNFILE("")
  ) dut_b (
    .rst_n(rst_n), .clk(clk),
    .addr0(addr0), .data0(data0), .we0(we0), .q0(qb0),
    .addr1(addr1), .data1(data1), .we1(we1), .q1(qb1),
    .clr(clr), .busy(busyb), .done(doneb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read value with same-cycle writes merged in, port 1 taking priority.
  function automatic logic [16:0] merged(input logic [3:0] ra,
                                         input logic [1:0] m0, input logic [3:0] a0, input logic [15:0] d0,
                                         input logic [1:0] m1, input logic [3:0] a1, input logic [15:0] d1);
    logic [15:0] v;
    logic [1:0]  cov;
    v   = model[ra];
    cov = 2'b00;
    for (int b = 0; b < 2; b++) begin
      if (m1[b] && a1 == ra) begin
        v[b*8 +: 8] = d1[b*8 +: 8];
        cov[b] = 1'b1;
      end else if (m0[b] && a0 == ra) begin
        v[b*8 +: 8] = d0[b*8 +: 8];
        cov[b] = 1'b1;
      end
    end
    return {known[ra] || cov == 2'b11, v};
  endfunction

  task automatic check_ctl();
    chk("a.busy", 16'(busya), 16'(mbusy));
    chk("b.busy", 16'(busyb), 16'(mbusy));
    chk("a.done", 16'(donea), 16'(edone));
    chk("b.done", 16'(doneb), 16'(edone));
  endtask

  task automatic check_rst_outputs(input string tag);
    chk({tag, ".qa0"}, qa0, 16'h0000);
    chk({tag, ".qa1"}, qa1, 16'h0000);
    chk({tag, ".qb0"}, qb0, 16'h0000);
    chk({tag, ".qb1"}, qb1, 16'h0000);
    check_ctl();
  endtask

  // One clock: drive, push expectations, update model, sample 1 time unit after the edge.
  task automatic tick(input logic [3:0] a0, input logic [15:0] d0, input logic [1:0] w0,
                      input logic [3:0] a1, input logic [15:0] d1, input logic [1:0] w1,
                      input logic c);
    logic [1:0]  m0, m1;
    logic [3:0]  wa1;
    logic [15:0] wd1;
    logic [16:0] r0, r1;
    exp_t        ea, eb, e;
    addr0 = a0; data0 = d0; we0 = w0;
    addr1 = a1; data1 = d1; we1 = w1;
    clr   = c;
    if (mbusy) begin
      m0 = 2'b00; m1 = 2'b11; wa1 = 4'(mcnt); wd1 = CV;
    end else begin
      m1 = w1; wa1 = a1; wd1 = d1;
      m0 = (a0 == a1) ? (w0 & ~w1) : w0;
    end
    ea.c0 = known[a0]; ea.e0 = model[a0];
    ea.c1 = known[a1]; ea.e1 = model[a1];
    r0 = merged(a0, m0, a0, d0, m1, wa1, wd1);
    r1 = merged(a1, m0, a0, d0, m1, wa1, wd1);
    eb.c0 = r0[16]; eb.e0 = r0[15:0];
    eb.c1 = r1[16]; eb.e1 = r1[15:0];
    sa.push_back(ea);
    sb.push_back(eb);
    for (int b = 0; b < 2; b++) begin
      if (m0[b]) model[a0][b*8 +: 8] = d0[b*8 +: 8];
      if (m1[b]) model[wa1][b*8 +: 8] = wd1[b*8 +: 8];
    end
    if (m0 == 2'b11) known[a0] = 1'b1;
    if (m1 == 2'b11) known[wa1] = 1'b1;
    edone = 1'b0;
    if (!mbusy) begin
      if (c) begin mbusy = 1'b1; mcnt = 0; end
    end else if (c) begin
      mcnt = 0;
    end else if (mcnt == N - 1) begin
      mbusy = 1'b0; mcnt = 0; edone = 1'b1;
    end else begin
      mcnt++;
    end
    @(posedge clk);
    #1;
    e = sa.pop_front();
    if (e.c0) chk("a.q0", qa0, e.e0);
    if (e.c1) chk("a.q1", qa1, e.e1);
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      if (e.c0) chk("b.q0", qb0, e.e0);
      if (e.c1) chk("b.q1", qb1, e.e1);
    end
    check_ctl();
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
    tick(a0, 16'h0000, 2'b00, a1, 16'h0000, 2'b00, 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) rd(4'(i), 4'(N - 1 - i));
    rd(4'd0, 4'd0);
    rd(4'd0, 4'd0);
  endtask

  task automatic run_to_idle(input string tag);
    int k;
    k = 0;
    while (mbusy && k < 40) begin
      tick(4'(k), 16'(16'hC000 + k), 2'b11, 4'(k + 3), 16'(16'hD000 + k), 2'b01, 1'b0);
      k++;
    end
    chk({tag, ".idle_bound"}, 16'(mbusy), 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    we0 = '0; we1 = '0; clr = 1'b0;
    mbusy = 1'b1; mcnt = 0; edone = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_rst_outputs("reset");

    // Boot clear: 16 busy cycles, single done pulse.
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) rd(4'(i), 4'(N - 1 - i));
    rd(4'd1, 4'd2);
    read_all();

    // Byte enables.
    tick(4'd3, 16'h1234, 2'b11, 4'd9, 16'h0000, 2'b00, 1'b0);
    tick(4'd3, 16'hFF00, 2'b10, 4'd3, 16'h0000, 2'b00, 1'b0);
    rd(4'd3, 4'd3);
    rd(4'd3, 4'd3);
    chk("byte_model", model[3], 16'hFF34);

    // Collision: port 1 owns the low lane.
    tick(4'd5, 16'h1111, 2'b11, 4'd5, 16'h2222, 2'b01, 1'b0);
    rd(4'd5, 4'd5);
    rd(4'd5, 4'd5);

    // Read-during-write across ports.
    tick(4'd7, 16'h0000, 2'b11, 4'd0, 16'h0000, 2'b00, 1'b0);
    tick(4'd7, 16'hBEEF, 2'b11, 4'd7, 16'h0000, 2'b00, 1'b0);
    rd(4'd7, 4'd7);
    rd(4'd7, 4'd7);

    // Writes dropped during clear; second clr restarts the count.
    tick(4'd0, 16'h0000, 2'b00, 4'd0, 16'h0000, 2'b00, 1'b1);
    for (int i = 0; i < N; i++)
      tick(4'(i), 16'($urandom), 2'b11, 4'(i), 16'($urandom), 2'b11, 1'(i == 5));
    run_to_idle("clear");
    read_all();

    // Reset in the middle of a clear.
    for (int i = 8; i < N; i++)
      tick(4'(i), 16'(16'h1000 + i), 2'b11, 4'(i - 8), 16'h0000, 2'b00, 1'b0);
    tick(4'd0, 16'h0000, 2'b00, 4'd0, 16'h0000, 2'b00, 1'b1);
    for (int k = 0; k < 40 && mcnt != 8; k++)
      tick(4'(k), 16'h4321, 2'b11, 4'd12, 16'h0000, 2'b00, 1'b0);
    chk("midclr.cnt_bound", 16'(mcnt), 16'd8);
    rst_n = 1'b0;
    #1;
    sa.delete();
    sb.delete();
    mbusy = 1'b1; mcnt = 0; edone = 1'b0;
    check_rst_outputs("midclr.rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_rst_outputs("midclr.hold");
    rst_n = 1'b1;
    rd(4'd12, 4'd12);
    rd(4'd12, 4'd9);
    rd(4'd12, 4'd12);
    chk("midclr.partial", model[12], 16'h100C);
    run_to_idle("midclr");
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
